instruction_fetch_arbiter: RTL
==============================

Name: instruction_fetch_arbiter

Overview:
- Sits directly downstream of the per-warp fetchers and upstream of the single-ported instruction memory.
- Collects NUM_WARPS fetcher read requests (valid plus address), grants one at a time in round-robin order, and drives the memory handshake.
- Returns the fetched word to the granted fetcher with a one-cycle ready pulse.
- Exactly one memory transaction is outstanding at any time.

Parameters:
- NUM_WARPS, 4, number of fetcher request ports (≥2).
- ADDR_WIDTH, 8, instruction memory address width.
- DATA_WIDTH, 16, instruction word width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_read_valid  in  NUM_WARPS  per-warp request; bit i is held high until fetch_read_ready[i] is seen.
- fetch_read_address  in  NUM_WARPS*ADDR_WIDTH  packed per-warp addresses; warp i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- fetch_read_ready  out  NUM_WARPS  one-hot, one-cycle pulse marking the response for warp i.
- fetch_read_data  out  DATA_WIDTH  response word, shared by all warps; valid only while a fetch_read_ready bit is high.
- mem_read_valid  out  1  memory request.
- mem_read_address  out  ADDR_WIDTH  memory request address.
- mem_read_ready  in  1  memory accepts the request and returns data in the same cycle.
- mem_read_data  in  DATA_WIDTH  memory data, sampled when mem_read_ready is high.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset==0 at a clock edge) forces:
  - state=IDLE, rr_ptr=NUM_WARPS-1, grant_idx=0.
  - fetch_read_ready=0, fetch_read_data=0, mem_read_valid=0, mem_read_address=0, busy=0.
- Reset mid-transaction aborts it. No ready pulse is issued, and mem_read_valid is low from the next cycle.
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - If any fetch_read_valid bit is high, select the first set bit searching (rr_ptr+1) mod NUM_WARPS upward with wrap-around.
  - Register grant_idx and latch that warp's address into mem_read_address, then go to REQ.
  - If no bit is high, stay in IDLE.
- REQ:
  - mem_read_valid=1 with the latched address, held stable until mem_read_ready is high.
  - On a cycle with mem_read_ready=1:
    - capture mem_read_data into fetch_read_data;
    - set rr_ptr=grant_idx;
    - go to RESP.
  - mem_read_valid is 0 from the next cycle.
- RESP:
  - fetch_read_ready[grant_idx]=1 for exactly this one cycle; all other bits are 0.
  - fetch_read_data holds the captured word.
  - Next state is IDLE unconditionally.
- Latency: a request seen in IDLE at cycle 0 gives mem_read_valid in cycle 1.
  - With mem_read_ready in cycle 1, the ready pulse comes in cycle 2.
  - Each memory wait cycle adds 1.
  - Back-to-back grants repeat every 3 cycles at minimum.
- Fairness: the warp just served has lowest priority in the next arbitration.
  - With all warps requesting continuously, grants cycle 0,1,2,3,0,…
- Address capture: the address is latched only in IDLE. Changes on fetch_read_address during REQ/RESP are ignored.
- Requester drops valid mid-flight: the transaction still completes and the ready pulse is still issued; the requester ignores it. The arbiter never cancels a memory request once mem_read_valid is high.
- Stale valid: fetchers drop valid on the edge after the ready pulse. The arbiter's IDLE cycle follows RESP, so a served warp is never re-granted on stale valid.
- A new request arriving during REQ/RESP waits. It is arbitrated in the next IDLE.
- fetch_read_ready and mem_read_valid are never high in the same cycle.
- busy=1 in REQ and RESP.

Test Plan:
1. Reset, then only warp 2 requests address 0x1A; memory is ready immediately with data 0xBEEF.
   - mem_read_valid/address=0x1A in cycle 1; fetch_read_ready=4'b0100 with data 0xBEEF in cycle 2; idle afterwards.
2. Memory stalls 3 cycles on warp 0 address 0x05.
   - mem_read_valid and address 0x05 are held stable for 4 cycles; the ready pulse comes exactly 1 cycle after mem_read_ready.
3. All 4 warps request continuously with addresses 0x10+i.
   - Grant order is 0,1,2,3,0; memory addresses are 0x10,0x11,0x12,0x13,0x10; one pulse every 3 cycles.
4. Warp 1 is served, then warps 1 and 3 request together.
   - Warp 3 is granted before warp 1 (round-robin from rr_ptr=1).
5. Warp 0's address changes from 0x20 to 0x30 during REQ.
   - Memory sees 0x20 throughout; the response goes to warp 0.
6. reset asserted low during REQ.
   - All outputs are 0 next cycle and no fetch_read_ready pulse occurs; a fresh request after reset completes normally.

Source files
------------

// File: rtl/instruction_fetch_arbiter.sv
// rtl/instruction_fetch_arbiter.sv - round-robin arbiter from per-warp fetchers to one instruction memory port
module instruction_fetch_arbiter #(
    parameter int NUM_WARPS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WARPS-1:0]            fetch_read_valid,
    input  logic [NUM_WARPS*ADDR_WIDTH-1:0] fetch_read_address,
    output logic [NUM_WARPS-1:0]            fetch_read_ready,
    output logic [DATA_WIDTH-1:0]           fetch_read_data,
    output logic                            mem_read_valid,
    output logic [ADDR_WIDTH-1:0]           mem_read_address,
    input  logic                            mem_read_ready,
    input  logic [DATA_WIDTH-1:0]           mem_read_data,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_WARPS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      pick;
    logic [IDX_W-1:0]      cand;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_WARPS];

    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            addr_arr[i] = fetch_read_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Walk from the farthest candidate back to rr_ptr+1 so the nearest set bit wins.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_WARPS);
            if (fetch_read_valid[cand]) begin
                pick = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            rr_ptr           <= IDX_W'(NUM_WARPS - 1);
            grant_idx        <= '0;
            fetch_read_data  <= '0;
            mem_read_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|fetch_read_valid) begin
                        grant_idx        <= pick;
                        mem_read_address <= addr_arr[pick];
                        state            <= REQ;
                    end
                end
                REQ: begin
                    if (mem_read_ready) begin
                        fetch_read_data <= mem_read_data;
                        rr_ptr          <= grant_idx;
                        state           <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read_valid   = (state == REQ);
    assign busy             = (state != IDLE);
    assign fetch_read_ready = (state == RESP) ? (NUM_WARPS'(1) << grant_idx) : '0;

endmodule
